// File: rtl/dvp_cam_emulator.sv
// DVP camera emulator: 12 MHz PCLK, VSYNC/HREF framing and a YCbCr 4:2:2 test-pattern byte stream.
// Frame sequence: IDLE -> VSYNC -> VBACK -> ACTIVE -> VFRONT, looping back to VSYNC while en stays high.
module dvp_cam_emulator #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_BLANK     = 288,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic        CLOCK_24,
  input  logic        reset_n,
  input  logic        en,
  input  logic [1:0]  pattern_sel,
  output logic        PCLK,
  output logic        VSYNC,
  output logic        HREF,
  output logic [7:0]  D,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT} state_t;

  localparam logic [15:0] LINE_M1 = 16'(2*H_ACTIVE + H_BLANK - 1);
  localparam logic [15:0] HACT2   = 16'(2*H_ACTIVE);

  state_t      state, state_nx;
  logic [15:0] hcnt, hcnt_nx, lcnt, lcnt_nx, lines_m1;
  logic [1:0]  pat, pat_nx;
  logic        tick, eof;
  logic        vsync_nx, href_nx;
  logic [7:0]  d_nx, yval, byte_nx;

  // A byte slot ends on the edge where PCLK falls; all framing moves on that edge only.
  assign tick = PCLK;

  always_comb begin
    lines_m1 = '0;
    case (state)
      S_VSYNC:  lines_m1 = 16'(VSYNC_LINES - 1);
      S_VBACK:  lines_m1 = 16'(V_BACK - 1);
      S_ACTIVE: lines_m1 = 16'(V_ACTIVE - 1);
      S_VFRONT: lines_m1 = 16'(V_FRONT - 1);
      default:  lines_m1 = '0;
    endcase
  end

  always_comb begin
    state_nx = state;
    hcnt_nx  = hcnt;
    lcnt_nx  = lcnt;
    eof      = 1'b0;
    if (state == S_IDLE) begin
      hcnt_nx = '0;
      lcnt_nx = '0;
      if (en) state_nx = S_VSYNC;
    end else if (hcnt == LINE_M1) begin
      hcnt_nx = '0;
      if (lcnt == lines_m1) begin
        lcnt_nx = '0;
        case (state)
          S_VSYNC:  state_nx = S_VBACK;
          S_VBACK:  state_nx = S_ACTIVE;
          S_ACTIVE: state_nx = S_VFRONT;
          S_VFRONT: begin
            eof      = 1'b1;
            state_nx = en ? S_VSYNC : S_IDLE;
          end
          default:  state_nx = S_IDLE;
        endcase
      end else begin
        lcnt_nx = lcnt + 16'd1;
      end
    end else begin
      hcnt_nx = hcnt + 16'd1;
    end
  end

  // Outputs are computed for the slot being entered; x = hcnt/2, y = active line index.
  always_comb begin
    pat_nx = (state_nx == S_VSYNC && state != S_VSYNC) ? pattern_sel : pat;
    yval   = 8'h00;
    case (pat_nx)
      2'd0: yval = hcnt_nx[10:3];
      2'd1: yval = lcnt_nx[8:1];
      2'd2: yval = (hcnt_nx[6] ^ lcnt_nx[5]) ? 8'hEB : 8'h10;
      default: yval = 8'h91;
    endcase
    byte_nx = yval;
    case (hcnt_nx[1:0])
      2'd0:    byte_nx = (pat_nx == 2'd3) ? 8'h36 : 8'h80;
      2'd2:    byte_nx = (pat_nx == 2'd3) ? 8'h22 : 8'h80;
      default: byte_nx = yval;
    endcase
    vsync_nx = (state_nx == S_VSYNC);
    href_nx  = (state_nx == S_ACTIVE) && (hcnt_nx < HACT2);
    d_nx     = href_nx ? byte_nx : 8'h00;
  end

  always_ff @(posedge CLOCK_24 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      hcnt       <= '0;
      lcnt       <= '0;
      pat        <= '0;
      PCLK       <= 1'b0;
      VSYNC      <= 1'b0;
      HREF       <= 1'b0;
      D          <= 8'h00;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      PCLK       <= ~PCLK;
      frame_done <= 1'b0;
      if (tick) begin
        state      <= state_nx;
        hcnt       <= hcnt_nx;
        lcnt       <= lcnt_nx;
        pat        <= pat_nx;
        VSYNC      <= vsync_nx;
        HREF       <= href_nx;
        D          <= d_nx;
        frame_done <= eof;
        if (eof) frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dvp_cam_emulator.sv
// Directed bench for dvp_cam_emulator using a reduced 40x36 frame so full frames fit in the run.
module tb_dvp_cam_emulator;
  localparam int HA = 40, HB = 8, VS = 2, VB = 2, VA = 36, VF = 2;
  localparam int LINE = 2*HA + HB;
  localparam int FRAME_SLOTS = (VS + VB + VA + VF) * LINE;

  logic        CLOCK_24 = 1'b0;
  logic        reset_n  = 1'b0;
  logic        en       = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic        PCLK, VSYNC, HREF, frame_done;
  logic [7:0]  D;
  logic [15:0] frame_cnt;

  int tests  = 0;
  int failed = 0;

  dvp_cam_emulator #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
    .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .CLOCK_24(CLOCK_24), .reset_n(reset_n), .en(en), .pattern_sel(pattern_sel),
    .PCLK(PCLK), .VSYNC(VSYNC), .HREF(HREF), .D(D),
    .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 CLOCK_24 = ~CLOCK_24;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic slots(input int n);
    repeat (2*n) @(posedge CLOCK_24);
    #1;
  endtask

  task automatic wait_href_rise(output bit ok);
    logic prev;
    ok = 1'b0;
    prev = HREF;
    for (int i = 0; i < 20000; i++) begin
      @(posedge CLOCK_24); #1;
      if (!prev && HREF) begin ok = 1'b1; break; end
      prev = HREF;
    end
  endtask

  task automatic wait_fd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge CLOCK_24); #1;
      if (frame_done) begin ok = 1'b1; break; end
    end
  endtask

  initial begin
    bit ok;
    int n, hr, k, errs, tog, vh, fd;
    logic prevh, prevp;
    logic [7:0] b [0:11];
    logic [7:0] exp_b;
    logic [7:0] grn [0:3];
    grn[0] = 8'h36; grn[1] = 8'h91; grn[2] = 8'h22; grn[3] = 8'h91;

    // Reset state
    repeat (4) @(posedge CLOCK_24); #1;
    chk("rst_pclk",  32'(PCLK), 0);
    chk("rst_vsync", 32'(VSYNC), 0);
    chk("rst_href",  32'(HREF), 0);
    chk("rst_d",     32'(D), 0);
    chk("rst_fd",    32'(frame_done), 0);
    chk("rst_cnt",   32'(frame_cnt), 0);

    // Start: VSYNC within 2 cycles of release, then VS lines long with HREF low
    en = 1'b1; pattern_sel = 2'd0;
    @(negedge CLOCK_24); reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLOCK_24); #1; n++;
      if (VSYNC) break;
    end
    chk("vsync_rise_lat", 32'(VSYNC && n <= 2), 1);
    n = 1; hr = 0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge CLOCK_24); #1;
      if (HREF) hr++;
      if (!VSYNC) break;
      n++;
    end
    chk("vsync_cycles", 32'(n), 32'(VS*LINE*2));
    chk("vsync_href_low", 32'(hr), 0);

    // Back porch length, then first active line with pattern 0
    n = 0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge CLOCK_24); #1; n++;
      if (HREF) break;
    end
    chk("vback_cycles", 32'(n), 32'(VB*LINE*2));
    errs = 0; hr = 0;
    for (int s = 0; s < LINE; s++) begin
      if (s < 12) b[s] = D;
      if (s < 2*HA) begin
        exp_b = (s % 2 == 0) ? 8'h80 : 8'((s/2)/4);
        if (HREF) hr++;
        if (D !== exp_b) errs++;
      end else begin
        if (HREF || D !== 8'h00) errs++;
      end
      slots(1);
    end
    chk("p0_b0", 32'(b[0]), 32'h80);
    chk("p0_b1", 32'(b[1]), 32'h00);
    chk("p0_b2", 32'(b[2]), 32'h80);
    chk("p0_b3", 32'(b[3]), 32'h00);
    chk("p0_x4_cb", 32'(b[8]), 32'h80);
    chk("p0_x4_y",  32'(b[9]), 32'h01);
    chk("p0_x5_y",  32'(b[11]), 32'h01);
    chk("p0_line_href_slots", 32'(hr), 32'(2*HA));
    chk("p0_line_errs", 32'(errs), 0);

    // Mid-frame pattern change must not affect the current frame
    pattern_sel = 2'd2;
    chk("line1_href", 32'(HREF), 1);
    slots(9);
    chk("p0_hold_y_x4", 32'(D), 32'h01);
    wait_fd(ok);
    chk("fd1_seen", 32'(ok), 1);
    chk("fd1_cnt", 32'(frame_cnt), 1);
    chk("b2b_vsync", 32'(VSYNC), 1);
    @(posedge CLOCK_24); #1;
    chk("fd1_width", 32'(frame_done), 0);

    // Frame 2: checkerboard; switch to pattern 1 for the next frame
    pattern_sel = 2'd1;
    wait_href_rise(ok);
    chk("f2_href", 32'(ok), 1);
    chk("cb_y0_cb", 32'(D), 32'h80);
    slots(1);
    chk("cb_x0_y0", 32'(D), 32'h10);
    slots(64);
    chk("cb_x32_y0", 32'(D), 32'hEB);
    for (int i = 0; i < 32; i++) wait_href_rise(ok);
    chk("f2_href32", 32'(ok), 1);
    slots(1);
    chk("cb_x0_y32", 32'(D), 32'hEB);
    slots(64);
    chk("cb_x32_y32", 32'(D), 32'h10);
    wait_fd(ok);
    chk("fd2_cnt", 32'(frame_cnt), 2);

    // Frame 3: vertical ramp, line y=2 has Y=0x01
    pattern_sel = 2'd3;
    for (int i = 0; i < 3; i++) wait_href_rise(ok);
    chk("f3_href", 32'(ok), 1);
    slots(1);
    chk("vr_y2_y0", 32'(D), 32'h01);
    slots(1);
    chk("vr_y2_cr", 32'(D), 32'h80);
    slots(1);
    chk("vr_y2_y1", 32'(D), 32'h01);
    wait_fd(ok);
    chk("fd3_cnt", 32'(frame_cnt), 3);

    // Frame 4: solid green full frame; en drops during active line 10
    n = 0; hr = 0; k = 0; errs = 0; fd = 0;
    while (n < FRAME_SLOTS + 100) begin
      prevh = HREF;
      slots(1); n++;
      if (HREF && !prevh) begin hr++; k = 0; end
      if (hr == 11 && en) en = 1'b0;
      if (HREF) begin
        if (D !== grn[k % 4]) errs++;
        k++;
      end else if (D !== 8'h00) errs++;
      if (frame_done) begin fd++; break; end
    end
    chk("g_frame_slots", 32'(n), 32'(FRAME_SLOTS));
    chk("g_href_pulses", 32'(hr), 32'(VA));
    chk("g_byte_errs", 32'(errs), 0);
    chk("g_fd", 32'(fd), 1);
    chk("fd4_cnt", 32'(frame_cnt), 4);
    chk("stop_vsync", 32'(VSYNC), 0);

    // Idle after en drop: no VSYNC, PCLK keeps running
    tog = 0; vh = 0; prevp = PCLK;
    for (int i = 0; i < 200; i++) begin
      @(posedge CLOCK_24); #1;
      if (PCLK !== prevp) tog++;
      if (VSYNC) vh++;
      prevp = PCLK;
    end
    chk("idle_pclk_tog", 32'(tog), 200);
    chk("idle_vsync", 32'(vh), 0);
    chk("idle_cnt", 32'(frame_cnt), 4);

    // Restart from idle, then reset mid active line 4
    pattern_sel = 2'd0; en = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLOCK_24); #1; n++;
      if (VSYNC) break;
    end
    chk("restart_vsync", 32'(VSYNC && n <= 2), 1);
    for (int i = 0; i < 5; i++) wait_href_rise(ok);
    slots(3);
    chk("pre_rst_href", 32'(HREF), 1);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_pclk_vsync_href", 32'({PCLK, VSYNC, HREF}), 0);
    chk("arst_d", 32'(D), 0);
    chk("arst_cnt", 32'(frame_cnt), 0);
    fd = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLOCK_24); #1;
      if (frame_done) fd++;
    end
    chk("arst_no_fd", 32'(fd), 0);
    @(negedge CLOCK_24); reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLOCK_24); #1; n++;
      if (VSYNC) break;
    end
    chk("post_rst_vsync", 32'(VSYNC && n <= 2), 1);
    chk("post_rst_cnt", 32'(frame_cnt), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
